// File: rtl/rsc_encoder_framed.sv
// Framed N_CH-lane 8-state RSC encoder: K data beats plus 3 self-generated tail beats per block (optional ENC_BLKCNT_EN adds blk_cnt).
// Latency: accepted input beat appears on x/z one cycle later; tail beats follow the last data beat back to back.
// Backpressure: single output register; in_ready and tail advance only when the slot is free; compute_enable low freezes all.
module rsc_encoder_framed #(
  parameter int N_CH = 2,
  parameter int KW   = 13
) (
  input  logic            clock,
  input  logic            sclr,
  input  logic            compute_enable,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_CH-1:0] c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_CH-1:0] x,
  output logic [N_CH-1:0] z,
  output logic            tail_flag,
  output logic            last,
  output logic            busy
`ifdef ENC_BLKCNT_EN
  ,
  output logic [15:0]     blk_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  typedef struct packed {
    logic [N_CH-1:0] x;
    logic [N_CH-1:0] z;
    logic            tail;
    logic            last;
  } beat_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, cnt_q;
  logic [1:0]      tcnt_q;
  logic [N_CH-1:0] s1_q, s2_q, s3_q;
  logic            out_vld_q;
  beat_t           beat_q;

  logic            slot_free, data_fire, tail_fire, start_ok;
  logic            data_last, tail_last;
  logic [N_CH-1:0] u_dat, a_dat, z_dat;

  assign slot_free = ~out_vld_q | out_ready;
  assign in_ready  = (state_q == DATA) & slot_free & compute_enable;
  assign data_fire = in_ready & in_valid;
  assign tail_fire = (state_q == TAIL) & slot_free & compute_enable;
  assign start_ok  = compute_enable & (state_q == IDLE) & start & (k_len != '0);
  assign data_last = data_fire & (cnt_q == k_q - KW'(1));
  assign tail_last = tail_fire & (tcnt_q == 2'd2);

  // Tail input cancels the feedback so three tail beats flush every lane to zero.
  always_comb begin
    u_dat = c;
    if (state_q == TAIL) u_dat = s2_q ^ s3_q;
    a_dat = u_dat ^ s2_q ^ s3_q;
    z_dat = a_dat ^ s1_q ^ s3_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)  state_d = DATA;
      DATA:    if (data_last) state_d = TAIL;
      TAIL:    if (tail_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      k_q       <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      out_vld_q <= 1'b0;
      beat_q    <= '0;
    end else if (compute_enable) begin
      if (start_ok) begin
        k_q    <= k_len;
        cnt_q  <= '0;
        tcnt_q <= '0;
        s1_q   <= '0;
        s2_q   <= '0;
        s3_q   <= '0;
      end
      if (data_fire) begin
        cnt_q <= cnt_q + KW'(1);
        if (data_last) tcnt_q <= '0;
      end
      if (tail_fire) tcnt_q <= tail_last ? 2'd0 : tcnt_q + 2'd1;
      if (data_fire | tail_fire) begin
        s3_q <= s2_q;
        s2_q <= s1_q;
        s1_q <= a_dat;
      end
      if (slot_free) begin
        out_vld_q <= data_fire | tail_fire;
        if (data_fire | tail_fire) begin
          beat_q.x    <= u_dat;
          beat_q.z    <= z_dat;
          beat_q.tail <= tail_fire;
          beat_q.last <= tail_last;
        end else begin
          beat_q <= '0;
        end
      end
    end
  end

`ifdef ENC_BLKCNT_EN
  always_ff @(posedge clock) begin
    if (sclr)
      blk_cnt <= '0;
    else if (compute_enable & out_vld_q & out_ready & beat_q.last)
      blk_cnt <= blk_cnt + 16'd1;
  end
`endif

  assign out_valid = out_vld_q;
  assign x         = beat_q.x;
  assign z         = beat_q.z;
  assign tail_flag = beat_q.tail;
  assign last      = beat_q.last;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rsc_encoder_framed.sv
// Bench for rsc_encoder_framed: directed and randomized blocks checked against a generator-polynomial model.
// Latency: one cycle input to output. Backpressure: random out_ready/compute_enable stalls checked for stability.
module tb_rsc_encoder_framed;
  localparam int N_CH = 2;
  localparam int KW   = 13;

  typedef struct packed {
    logic [N_CH-1:0] x;
    logic [N_CH-1:0] z;
    logic            t;
    logic            l;
  } beat_t;

  logic            clock = 1'b0;
  logic            sclr, compute_enable, start, in_valid, in_ready;
  logic [KW-1:0]   k_len;
  logic [N_CH-1:0] c, x, z;
  logic            out_valid, out_ready, tail_flag, last, busy;
`ifdef ENC_BLKCNT_EN
  logic [15:0]     blk_cnt;
`endif

  always #5 clock = ~clock;

  rsc_encoder_framed #(.N_CH(N_CH), .KW(KW)) dut (
    .clock(clock), .sclr(sclr), .compute_enable(compute_enable), .start(start),
    .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .z(z),
    .tail_flag(tail_flag), .last(last), .busy(busy)
`ifdef ENC_BLKCNT_EN
    , .blk_cnt(blk_cnt)
`endif
  );

  int              vectors = 0;
  int              miscompares = 0;
  int              blocks_done = 0;
  beat_t           exp_q[$];
  logic [N_CH-1:0] din[$];
  logic            lit_x[$];
  logic            lit_z[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // a[n] = u[n] + a[n-2] + a[n-3] (1/g0), z[n] = a[n] + a[n-1] + a[n-3] (g1); tail picks u so a[n] = 0.
  task automatic build_expected(input int k);
    int    a[N_CH][$];
    beat_t b;
    int    am1, am2, am3, u;
    exp_q.delete();
    for (int ch = 0; ch < N_CH; ch++) a[ch].delete();
    for (int n = 0; n < k + 3; n++) begin
      b = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        am1 = (n >= 1) ? a[ch][n-1] : 0;
        am2 = (n >= 2) ? a[ch][n-2] : 0;
        am3 = (n >= 3) ? a[ch][n-3] : 0;
        if (n < k) begin
          u = int'(din[n][ch]);
          a[ch].push_back(u ^ am2 ^ am3);
        end else begin
          u = am2 ^ am3;
          a[ch].push_back(0);
        end
        b.x[ch] = 1'(u);
        b.z[ch] = 1'(a[ch][n] ^ am1 ^ am3);
      end
      b.t = (n >= k);
      b.l = (n == k + 2);
      exp_q.push_back(b);
    end
  endtask

  task automatic run_block(input int k, input bit rnd, input int abort_at, input bit mid_start);
    int    idx = 0, got = 0, first_out = -1, last_cyc = -1;
    int    budget = 30 * (k + 3) + 100;
    bit    hold = 0, done = 0, aborted = 0;
    beat_t held, cur, e;
    build_expected(k);
    sclr = 0; start = 1; k_len = KW'(k); in_valid = 0; out_ready = 1; compute_enable = 1; c = '0;
    #1;
    chk("in_ready_cycle0", 32'(in_ready), 0);
    for (int cyc = 1; cyc < budget && !done; cyc++) begin
      step();
      start          = mid_start && (idx == 2);
      k_len          = KW'(5);
      sclr           = (abort_at > 0) && (idx == abort_at);
      compute_enable = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      in_valid       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready      = sclr ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      c              = (idx < k) ? din[idx] : '0;
      #1;
      cur = {x, z, tail_flag, last};
      if (hold) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_beat", 32'(cur), 32'(held));
      end
      if (sclr) begin
        step();
        sclr = 0; start = 0; in_valid = 0; out_ready = 1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        blocks_done = 0;
        aborted = 1;
        done = 1;
        break;
      end
      if (!rnd && cyc == 1) chk("in_ready_cycle1", 32'(in_ready), 1);
      hold = out_valid && !(out_ready && compute_enable);
      held = cur;
      if (hold) chk("in_ready_stalled", 32'(in_ready), 0);
      if (in_ready && in_valid) idx++;
      if (out_valid && out_ready && compute_enable) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", 32'(cur), 32'(e));
        end
        if (got < lit_x.size()) chk("lit_x0", 32'(x[0]), 32'(lit_x[got]));
        if (got < lit_z.size()) chk("lit_z0", 32'(z[0]), 32'(lit_z[got]));
        if (first_out < 0) first_out = cyc;
        got++;
        if (last) begin
          chk("busy_at_last", 32'(busy), 0);
          last_cyc = cyc;
          blocks_done++;
          done = 1;
        end
      end
    end
    if (!done) chk("timeout", 0, 1);
    if (!aborted) begin
      chk("beat_count", 32'(got), 32'(k + 3));
      chk("exp_empty", 32'(exp_q.size()), 0);
      if (!rnd) begin
        chk("first_out_cycle", 32'(first_out), 2);
        chk("last_cycle", 32'(last_cyc), 32'(k + 4));
      end
      step();
      start = 0; in_valid = 0; out_ready = 1; compute_enable = 1;
      #1;
      chk("idle_after", 32'({out_valid, busy, in_ready}), 0);
    end
    lit_x.delete();
    lit_z.delete();
  endtask

  task automatic fill_random(input int k);
    din.delete();
    for (int i = 0; i < k; i++) din.push_back(N_CH'($urandom));
  endtask

  task automatic fill_first();
    din.delete();
    din.push_back(2'b01); din.push_back(2'b00); din.push_back(2'b00); din.push_back(2'b00);
    for (int i = 0; i < 7; i++) lit_z.push_back(1'b1);
  endtask

  initial begin
    sclr = 1; compute_enable = 0; start = 0; k_len = '0; in_valid = 0; c = '0; out_ready = 0;
    step(); step();
    chk("reset_outputs", 32'({out_valid, in_ready, x, z, tail_flag, last, busy}), 0);
    sclr = 0; compute_enable = 1;
    step();

    fill_first();
    run_block(4, 0, 0, 0);

    din.delete();
    din.push_back(2'b01);
    lit_x.push_back(1'b1); lit_x.push_back(1'b0); lit_x.push_back(1'b1); lit_x.push_back(1'b1);
    lit_z.push_back(1'b1); lit_z.push_back(1'b1); lit_z.push_back(1'b0); lit_z.push_back(1'b1);
    run_block(1, 0, 0, 0);

    step();
    start = 1; k_len = '0;
    step();
    start = 0;
    #1;
    chk("klen0_busy", 32'(busy), 0);
    chk("klen0_in_ready", 32'(in_ready), 0);
    step();
    chk("klen0_busy_later", 32'(busy), 0);

    fill_random(40);
    run_block(40, 1, 0, 1);

`ifdef ENC_BLKCNT_EN
    chk("blk_cnt_3", 32'(blk_cnt), 32'(blocks_done));
`endif

    fill_random(40);
    run_block(40, 0, 10, 0);
    step();
    fill_first();
    run_block(4, 0, 0, 0);

    for (int b = 0; b < 4; b++) begin
      int k = $urandom_range(1, 20);
      fill_random(k);
      run_block(k, 1, 0, 0);
    end

`ifdef ENC_BLKCNT_EN
    chk("blk_cnt_end", 32'(blk_cnt), 32'(blocks_done));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
